link_rx: RTL and testbench
==========================

# link_rx

Receive end of the inter-board UART link. Deserialises the `rx` line (8N1), parses fixed 4-byte frames and presents the opponent's direction, the shared point seed and the remote start request to the game logic. It also raises a sticky connection error when the peer goes silent during a game. Sits beside `communicate` in `top`, feeding `move_n_collisions`, `generate_point` and `mode_control`.

## Interface
- `CLK_HZ`, 75_000_000 — `clk` frequency.
- `BAUD`, 115_200 — line rate; oversampling divisor `OSR_DIV = round(CLK_HZ/(BAUD*16))`.
- `TIMEOUT_TICKS`, 4 — `send` ticks without a valid frame before `con_error`.
- `GAP_BITS`, 40 — maximum idle bit-times between bytes of one frame.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, 75 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `send`  in  1  one-cycle game tick (`clk_divided`), used only as the timeout time base.
- `active`  in  1  high while a multiplayer game runs; arms the timeout.
- `dir2`  out  `direction`  last valid remote direction.
- `rcvdir`  out  1  one-cycle pulse: `dir2` updated.
- `seed_x_out`, `seed_y_out`  out  5 each  last valid remote seed.
- `seed_rdy`  out  1  one-cycle pulse: seed updated.
- `start_game`  out  1  one-cycle pulse: START frame received.
- `con_error`  out  1  sticky link-loss flag.
- `frame_err_cnt`  out  8  saturating count of discarded frames (debug).

## Operation
- `rx` passes through a 2-flop synchroniser; reset value 1.
- Byte receiver: 16× oversampling. Falling edge starts a byte; start bit is re-checked at sample 8, and a high level there aborts. Data bits are taken LSB first at sample 8 of each bit. Stop bit must be high; if low, the byte is dropped and `byte_ferr` pulses.
- Frame: `HDR, P0, P1, CHK`, with `HDR = 8'hA0 | type`. Type values: 0 = DIR, 1 = SEED, 2 = START; 3 is invalid. `CHK = HDR ^ P0 ^ P1`.
  - DIR: `P0[1:0]` is the `direction` code (0 UP, 1 RIGHT, 2 DOWN, 3 LEFT).
  - SEED: `P0[4:0]` is x, `P1[4:0]` is y.
  - START: payload is ignored.
- Parser FSM: `IDLE → GOT_HDR → GOT_P0 → GOT_P1 → IDLE`.
  - In `IDLE`, only bytes with `[7:2] == 6'b101000` and type ≠ 3 are accepted as a header. Other bytes are silently skipped; this is resync and does not count as an error.
  - The `CHK` byte is compared in `GOT_P1`.
  - A mismatch, a `byte_ferr` in any non-`IDLE` state, or more than `GAP_BITS` bit-times between bytes discards the frame, increments `frame_err_cnt` (saturating at 255) and returns to `IDLE`.
- On a valid frame only the fields of its type are updated, and the matching pulse is issued.
- Timeout counter:
  - Cleared by any valid frame and while `active` = 0.
  - Otherwise it increments on each `send`.
  - Reaching `TIMEOUT_TICKS` sets `con_error`.
  - `con_error` clears only on `rst` or on a valid START frame.
- Reset values: `dir2` = RIGHT, seeds 0, all pulses 0, `con_error` 0, `frame_err_cnt` 0, FSM `IDLE`, byte receiver idle.

## Timing
- Byte strobe is asserted on the `clk` after the stop-bit mid-sample.
- Output pulse latency is one `clk` after the CHK byte strobe; data outputs are valid in the same cycle as their pulse.
- Pulses are always exactly one cycle wide, and at most one fires per frame.
- A valid frame and a `send` in the same cycle: the frame wins, the counter goes to 0 and `con_error` is not set.
- A valid START in the same cycle as the timeout expiry: `con_error` stays 0.
- `rst` mid-byte or mid-frame: the partial frame is lost with no pulse and no error count, and the link resyncs on the next header.
- Back-to-back frames with no idle gap are required to parse without loss.

## Structure
- In `snake_pkg`: the `direction` type, the frame type enum (`FRM_DIR`, `FRM_SEED`, `FRM_START`), `FRAME_SYNC = 6'b101000`, and the default `BAUD`. The transmit side uses the same constants.
- Sub-module `uart_rx_byte`: synchroniser, oversampler and deserialiser, with outputs `byte_data[7:0]`, `byte_vld`, `byte_ferr` and a `bit_tick` for gap timing. The parser, outputs and timeout logic stay in `link_rx`.

## Test plan
- DIR frame `A0 03 00 A3` → `rcvdir` pulse, `dir2` = LEFT, no other pulse, `frame_err_cnt` = 0.
- SEED frame `A1 11 07 B7` → `seed_rdy` pulse, `seed_x_out` = 17, `seed_y_out` = 7.
- Corrupt CHK `A0 01 00 00` → no pulse, `frame_err_cnt` = 1; a following valid DIR frame parses correctly.
- Junk `55 FF` then `A2 00 00 A2` → junk skipped, `start_game` pulse, `frame_err_cnt` = 0.
- With `active` = 1 and no traffic for 4 `send` ticks → `con_error` = 1. A later START frame clears it; `active` = 0 holds the counter at 0.
- Stop bit forced low on P0 of a DIR frame, and separately a 50 bit-time gap after HDR → frame discarded, count +1; `rst` asserted mid-frame → all outputs return to reset values.

Source files
------------

// File: rtl/link_rx_pkg.sv
// Shared link constants and types for the inter-board UART link.
// The transmit side uses the same frame encoding.
package link_rx_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } direction;

    // Type code 3 is reserved as invalid and never decoded.
    typedef enum logic [1:0] {
        FRM_DIR   = 2'd0,
        FRM_SEED  = 2'd1,
        FRM_START = 2'd2
    } frame_type_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_GOT_HDR,
        P_GOT_P0,
        P_GOT_P1
    } parse_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [5:0]  FRAME_SYNC   = 6'b101000;
    localparam int unsigned DEFAULT_BAUD = 115_200;

    function automatic logic [7:0] frame_chk(input logic [7:0] hdr,
                                             input logic [7:0] p0,
                                             input logic [7:0] p1);
        return hdr ^ p0 ^ p1;
    endfunction

endpackage

// File: rtl/link_rx_if.sv
// Bundle between the link receiver and the game logic.
interface link_rx_if import link_rx_pkg::*; ();
    logic       rx;
    logic       send;
    logic       active;
    direction   dir2;
    logic       rcvdir;
    logic [4:0] seed_x_out;
    logic [4:0] seed_y_out;
    logic       seed_rdy;
    logic       start_game;
    logic       con_error;
    logic [7:0] frame_err_cnt;

    modport master (
        output rx, send, active,
        input  dir2, rcvdir, seed_x_out, seed_y_out, seed_rdy,
               start_game, con_error, frame_err_cnt
    );

    modport slave (
        input  rx, send, active,
        output dir2, rcvdir, seed_x_out, seed_y_out, seed_rdy,
               start_game, con_error, frame_err_cnt
    );
endinterface

// File: rtl/link_rx_uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, 16x oversampling, LSB-first shift.
// bit_tick pulses once per bit-time while the line is idle between bytes.
module uart_rx_byte import link_rx_pkg::*; #(
    parameter int unsigned OSR_DIV = 41
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_vld,
    output logic       byte_ferr,
    output logic       bit_tick
);
    localparam int unsigned DIV_W = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;

    rx_state_t        r_state, w_state_nxt;
    logic [1:0]       r_sync;
    logic             r_prev;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_smp;
    logic [3:0]       r_bitdiv;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_vld, r_ferr;
    logic             w_rx, w_fall, w_os_tick, w_mid_start, w_mid_bit;

    assign w_rx        = r_sync[1];
    assign w_fall      = r_prev & ~w_rx;
    assign w_os_tick   = (r_div == DIV_W'(OSR_DIV - 1));
    assign w_mid_start = w_os_tick && (r_smp == 4'd7);
    assign w_mid_bit   = w_os_tick && (r_smp == 4'd15);

    assign byte_data = r_shift;
    assign byte_vld  = r_vld;
    assign byte_ferr = r_ferr;
    assign bit_tick  = (r_state == RX_IDLE) && w_os_tick && (r_bitdiv == 4'd15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], rx};
            r_prev <= w_rx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RX_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_IDLE:  if (w_fall) w_state_nxt = RX_START;
            RX_START: if (w_mid_start) w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_mid_bit && (r_bit_idx == 3'd7)) w_state_nxt = RX_STOP;
            RX_STOP:  if (w_mid_bit) w_state_nxt = RX_IDLE;
            default:  w_state_nxt = RX_IDLE;
        endcase
    end

    // Divider restarts on the start edge so samples land mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div     <= '0;
            r_smp     <= '0;
            r_bitdiv  <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_vld     <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_vld  <= 1'b0;
            r_ferr <= 1'b0;
            if ((r_state == RX_IDLE && w_fall) || w_os_tick) r_div <= '0;
            else                                             r_div <= r_div + DIV_W'(1);
            if (w_os_tick) r_bitdiv <= r_bitdiv + 4'd1;
            if (r_state == RX_IDLE || (r_state == RX_START && w_mid_start)) r_smp <= '0;
            else if (w_os_tick)                                            r_smp <= r_smp + 4'd1;
            if (r_state == RX_IDLE) r_bit_idx <= '0;
            if (r_state == RX_DATA && w_mid_bit) begin
                r_shift   <= {w_rx, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (r_state == RX_STOP && w_mid_bit) begin
                r_vld  <= w_rx;
                r_ferr <= ~w_rx;
            end
        end
    end
endmodule

// File: rtl/link_rx.sv
// Link receiver: parses 4-byte HDR/P0/P1/CHK frames into game-side updates
// and flags a sticky connection error when the peer stays silent in-game.
module link_rx import link_rx_pkg::*; #(
    parameter int unsigned CLK_HZ        = 75_000_000,
    parameter int unsigned BAUD          = DEFAULT_BAUD,
    parameter int unsigned TIMEOUT_TICKS = 4,
    parameter int unsigned GAP_BITS      = 40
) (
    input logic      clk,
    input logic      rst,
    link_rx_if.slave bus
);
    localparam int unsigned OSR_DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int unsigned GAP_W   = $clog2(GAP_BITS + 1);
    localparam int unsigned TO_W    = $clog2(TIMEOUT_TICKS + 1);

    logic [7:0]       w_byte_data;
    logic             w_byte_vld, w_byte_ferr, w_bit_tick;
    parse_state_t     r_state, w_state_nxt;
    logic [7:0]       r_hdr, r_p0, r_p1;
    logic [GAP_W-1:0] r_gap;
    logic [TO_W-1:0]  r_to_cnt;
    direction         r_dir2;
    logic [4:0]       r_seed_x, r_seed_y;
    logic             r_rcvdir, r_seed_rdy, r_start, r_con_error;
    logic [7:0]       r_err_cnt;
    logic             w_is_hdr, w_gap_err, w_abort, w_chk_hit, w_frame_ok, w_frame_bad;
    logic             w_start_ok, w_to_hit;

    uart_rx_byte #(.OSR_DIV(OSR_DIV)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (bus.rx),
        .byte_data (w_byte_data),
        .byte_vld  (w_byte_vld),
        .byte_ferr (w_byte_ferr),
        .bit_tick  (w_bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= P_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) w_state_nxt = P_IDLE;
        else begin
            case (r_state)
                P_IDLE:    if (w_is_hdr)   w_state_nxt = P_GOT_HDR;
                P_GOT_HDR: if (w_byte_vld) w_state_nxt = P_GOT_P0;
                P_GOT_P0:  if (w_byte_vld) w_state_nxt = P_GOT_P1;
                P_GOT_P1:  if (w_byte_vld) w_state_nxt = P_IDLE;
                default:   w_state_nxt = P_IDLE;
            endcase
        end
    end

    always_comb begin
        w_is_hdr    = w_byte_vld && (w_byte_data[7:2] == FRAME_SYNC) && (w_byte_data[1:0] != 2'd3);
        w_gap_err   = (r_state != P_IDLE) && w_bit_tick && (r_gap == GAP_W'(GAP_BITS));
        w_abort     = (r_state != P_IDLE) && (w_byte_ferr || w_gap_err);
        w_chk_hit   = (r_state == P_GOT_P1) && w_byte_vld && !w_abort;
        w_frame_ok  = w_chk_hit && (w_byte_data == frame_chk(r_hdr, r_p0, r_p1));
        w_frame_bad = w_abort || (w_chk_hit && !w_frame_ok);
        w_start_ok  = w_frame_ok && (r_hdr[1:0] == FRM_START);
        w_to_hit    = bus.active && bus.send && !w_frame_ok &&
                      (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1));
    end

    // Gap counter only advances on idle bit-times, so byte bodies never count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr <= '0;
            r_p0  <= '0;
            r_p1  <= '0;
            r_gap <= '0;
        end else begin
            if (r_state == P_IDLE && w_is_hdr)      r_hdr <= w_byte_data;
            if (r_state == P_GOT_HDR && w_byte_vld) r_p0  <= w_byte_data;
            if (r_state == P_GOT_P0 && w_byte_vld)  r_p1  <= w_byte_data;
            if (w_state_nxt == P_IDLE || w_byte_vld) r_gap <= '0;
            else if (w_bit_tick)                     r_gap <= r_gap + GAP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir2     <= DIR_RIGHT;
            r_seed_x   <= '0;
            r_seed_y   <= '0;
            r_rcvdir   <= 1'b0;
            r_seed_rdy <= 1'b0;
            r_start    <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_rcvdir   <= 1'b0;
            r_seed_rdy <= 1'b0;
            r_start    <= 1'b0;
            if (w_frame_ok) begin
                case (r_hdr[1:0])
                    FRM_DIR: begin
                        r_dir2   <= direction'(r_p0[1:0]);
                        r_rcvdir <= 1'b1;
                    end
                    FRM_SEED: begin
                        r_seed_x   <= r_p0[4:0];
                        r_seed_y   <= r_p1[4:0];
                        r_seed_rdy <= 1'b1;
                    end
                    FRM_START: r_start <= 1'b1;
                    default: ;
                endcase
            end
            if (w_frame_bad && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt    <= '0;
            r_con_error <= 1'b0;
        end else begin
            if (w_frame_ok || !bus.active) r_to_cnt <= '0;
            else if (bus.send && r_to_cnt != TO_W'(TIMEOUT_TICKS)) r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_start_ok)    r_con_error <= 1'b0;
            else if (w_to_hit) r_con_error <= 1'b1;
        end
    end

    assign bus.dir2          = r_dir2;
    assign bus.rcvdir        = r_rcvdir;
    assign bus.seed_x_out    = r_seed_x;
    assign bus.seed_y_out    = r_seed_y;
    assign bus.seed_rdy      = r_seed_rdy;
    assign bus.start_game    = r_start;
    assign bus.con_error     = r_con_error;
    assign bus.frame_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_link_rx.sv
// Directed bench for link_rx: frames are serialised at a reduced line rate
// (2 clocks per oversample) and checked against hand-computed results.
module tb_link_rx;
    import link_rx_pkg::*;

    localparam int unsigned BIT_CLKS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    int unsigned tot_dir = 0, tot_seed = 0, tot_start = 0;
    int unsigned b_dir, b_seed, b_start;
    logic [1:0] dir_at_pulse = 2'd0;

    link_rx_if bus();

    link_rx #(
        .CLK_HZ        (800_000),
        .BAUD          (25_000),
        .TIMEOUT_TICKS (4),
        .GAP_BITS      (40)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rcvdir) begin
            tot_dir++;
            dir_at_pulse = bus.dir2;
        end
        if (bus.seed_rdy)   tot_seed++;
        if (bus.start_game) tot_start++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h) need %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic idle_bits(input int unsigned n);
        bus.rx = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        bus.rx = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
        bus.rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] p0,
                              input logic [7:0] p1, input logic [7:0] c);
        send_byte(h, 1'b1);
        send_byte(p0, 1'b1);
        send_byte(p1, 1'b1);
        send_byte(c, 1'b1);
        idle_bits(2);
    endtask

    task automatic mark();
        b_dir   = tot_dir;
        b_seed  = tot_seed;
        b_start = tot_start;
    endtask

    task automatic tick();
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.rx     = 1'b1;
        bus.send   = 1'b0;
        bus.active = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_dir2",   bus.dir2, DIR_RIGHT);
        check_eq("rst_seedx",  bus.seed_x_out, 0);
        check_eq("rst_pulses", {bus.rcvdir, bus.seed_rdy, bus.start_game}, 0);
        check_eq("rst_conerr", bus.con_error, 0);
        check_eq("rst_errcnt", bus.frame_err_cnt, 0);
        rst = 1'b0;
        idle_bits(2);

        mark();
        send_frame(8'hA0, 8'h03, 8'h00, 8'hA3);
        check_eq("dir_pulses", tot_dir - b_dir, 1);
        check_eq("dir_val",    bus.dir2, DIR_LEFT);
        check_eq("dir_atpulse", dir_at_pulse, DIR_LEFT);
        check_eq("dir_other",  (tot_seed - b_seed) + (tot_start - b_start), 0);
        check_eq("dir_errcnt", bus.frame_err_cnt, 0);

        mark();
        send_frame(8'hA1, 8'h11, 8'h07, 8'hB7);
        check_eq("seed_pulses", tot_seed - b_seed, 1);
        check_eq("seed_x",      bus.seed_x_out, 17);
        check_eq("seed_y",      bus.seed_y_out, 7);
        check_eq("seed_other",  (tot_dir - b_dir) + (tot_start - b_start), 0);

        mark();
        send_frame(8'hA0, 8'h01, 8'h00, 8'h00);
        check_eq("badchk_pulses", (tot_dir - b_dir) + (tot_seed - b_seed) + (tot_start - b_start), 0);
        check_eq("badchk_errcnt", bus.frame_err_cnt, 1);
        check_eq("badchk_dir",    bus.dir2, DIR_LEFT);
        send_frame(8'hA0, 8'h01, 8'h00, 8'hA1);
        check_eq("after_bad_pulses", tot_dir - b_dir, 1);
        check_eq("after_bad_dir",    bus.dir2, DIR_RIGHT);

        mark();
        send_byte(8'h55, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_frame(8'hA2, 8'h00, 8'h00, 8'hA2);
        check_eq("junk_start",  tot_start - b_start, 1);
        check_eq("junk_errcnt", bus.frame_err_cnt, 1);

        bus.active = 1'b1;
        tick(); tick(); tick();
        check_eq("to_3ticks", bus.con_error, 0);
        tick();
        check_eq("to_4ticks", bus.con_error, 1);
        tick();
        check_eq("to_sticky", bus.con_error, 1);
        send_frame(8'hA2, 8'h00, 8'h00, 8'hA2);
        check_eq("to_start_clear", bus.con_error, 0);
        bus.active = 1'b0;
        repeat (6) tick();
        bus.active = 1'b1;
        tick(); tick(); tick();
        check_eq("to_inactive_hold", bus.con_error, 0);
        bus.active = 1'b0;
        repeat (3) @(negedge clk);

        mark();
        send_byte(8'hA0, 1'b1);
        send_byte(8'h03, 1'b0);
        idle_bits(4);
        send_byte(8'h00, 1'b1);
        send_byte(8'hA3, 1'b1);
        idle_bits(2);
        check_eq("ferr_pulses", tot_dir - b_dir, 0);
        check_eq("ferr_errcnt", bus.frame_err_cnt, 2);
        send_frame(8'hA0, 8'h02, 8'h00, 8'hA2);
        check_eq("ferr_recover", bus.dir2, DIR_DOWN);

        mark();
        send_byte(8'hA0, 1'b1);
        idle_bits(50);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hA3, 1'b1);
        idle_bits(2);
        check_eq("gap_pulses", tot_dir - b_dir, 0);
        check_eq("gap_errcnt", bus.frame_err_cnt, 3);
        check_eq("gap_dir",    bus.dir2, DIR_DOWN);

        bus.active = 1'b1;
        repeat (4) tick();
        check_eq("pre_rst_conerr", bus.con_error, 1);
        bus.active = 1'b0;

        mark();
        send_byte(8'hA1, 1'b1);
        send_byte(8'h05, 1'b1);
        bus.rx = 1'b0;
        repeat (3 * BIT_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midrst_dir",    bus.dir2, DIR_RIGHT);
        check_eq("midrst_errcnt", bus.frame_err_cnt, 0);
        check_eq("midrst_conerr", bus.con_error, 0);
        check_eq("midrst_seedx",  bus.seed_x_out, 0);
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_bits(4);
        check_eq("midrst_pulses", (tot_dir - b_dir) + (tot_seed - b_seed) + (tot_start - b_start), 0);

        mark();
        send_frame(8'hA1, 8'h0A, 8'h15, 8'hBE);
        check_eq("resync_seed_pulses", tot_seed - b_seed, 1);
        check_eq("resync_seed_x", bus.seed_x_out, 10);
        check_eq("resync_seed_y", bus.seed_y_out, 21);
        check_eq("resync_errcnt", bus.frame_err_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
